// File: rtl/audio_i2s_tx_pkg.sv
// Shared constants and types for the I2S speaker transmitter.
// Counter geometry fixes mclk/sck/lrck ratios against the 100 MHz clk.
package audio_pkg;

    localparam int SAMPLE_W = 16;
    localparam int SLOT_W   = 32;
    localparam int CNT_W    = 10;

    localparam logic [CNT_W-1:0] LOAD_CNT = 10'd1023;

    localparam int MCLK_BIT = 1;
    localparam int SCK_BIT  = 3;
    localparam int LRCK_BIT = 9;

    // Width of the slot index carved out of the counter.
    localparam int SLOT_IW = LRCK_BIT - SCK_BIT - 1;

endpackage

// File: rtl/audio_i2s_tx_if.sv
// Sample-pair stream from the mixer into the I2S transmitter.
// Plain valid/ready: the pair moves when both are high.
interface audio_i2s_tx_if
    import audio_pkg::*;
#(
    parameter int W = audio_pkg::SAMPLE_W
);
    logic [W-1:0] sample_left;
    logic [W-1:0] sample_right;
    logic         sample_valid;
    logic         sample_ready;

    modport master (
        output sample_left,
        output sample_right,
        output sample_valid,
        input  sample_ready
    );

    modport slave (
        input  sample_left,
        input  sample_right,
        input  sample_valid,
        output sample_ready
    );
endinterface

// File: rtl/audio_i2s_tx_clkgen.sv
// Free-running frame counter and derived I2S clocks.
// Also exports the upcoming slot/channel and the frame-load strobe.
module i2s_clkgen
    import audio_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    output logic               mclk_o,
    output logic               sck_o,
    output logic               lrck_o,
    output logic [SLOT_IW-1:0] slot_o,
    output logic               nxt_lr_o,
    output logic               bit_edge_o,
    output logic               load_o
);
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign cnt_d = cnt_q + CNT_W'(1);

    // Counter wraps 1023 -> 0 on its own width.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign mclk_o = cnt_q[MCLK_BIT];
    assign sck_o  = cnt_q[SCK_BIT];
    assign lrck_o = cnt_q[LRCK_BIT];

    // Slot and channel of the cycle after this one; sdin is
    // registered, so it is prepared one cycle ahead.
    assign slot_o   = cnt_d[LRCK_BIT-1:SCK_BIT+1];
    assign nxt_lr_o = cnt_d[LRCK_BIT];

    assign bit_edge_o = &cnt_q[SCK_BIT:0];
    assign load_o     = (cnt_q == LOAD_CNT);
endmodule

// File: rtl/audio_i2s_tx.sv
// Frame-aligned I2S transmitter for the CS4344 speaker DAC.
// One staged pair feeds the active pair at each frame boundary.
module audio_i2s_tx
    import audio_pkg::*;
#(
    parameter int SAMPLE_W = audio_pkg::SAMPLE_W,
    parameter int SLOT_W   = audio_pkg::SLOT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    audio_i2s_tx_if.slave        s_if,
    input  logic                 mute,
    output logic                 underrun,
    output logic                 audio_mclk,
    output logic                 audio_lrck,
    output logic                 audio_sck,
    output logic                 audio_sdin
);
    localparam int IDX_W = $clog2(SAMPLE_W);

    logic               load;
    logic               bit_edge;
    logic               nxt_lr;
    logic [SLOT_IW-1:0] slot;

    logic                full_q;
    logic                full_d;
    logic                ready_q;
    logic                accept;
    logic [SAMPLE_W-1:0] stg_l_q;
    logic [SAMPLE_W-1:0] stg_r_q;
    logic [SAMPLE_W-1:0] act_l_q;
    logic [SAMPLE_W-1:0] act_r_q;
    logic                sdin_q;
    logic                sdin_d;

    int unsigned         si;
    logic                in_rng;
    logic [IDX_W-1:0]    idx;

    i2s_clkgen u_clkgen (
        .clk        (clk),
        .rst        (rst),
        .mclk_o     (audio_mclk),
        .sck_o      (audio_sck),
        .lrck_o     (audio_lrck),
        .slot_o     (slot),
        .nxt_lr_o   (nxt_lr),
        .bit_edge_o (bit_edge),
        .load_o     (load)
    );

    assign accept            = s_if.sample_valid & ready_q;
    assign s_if.sample_ready = ready_q;
    assign underrun          = load & ~full_q & ~rst;
    assign audio_sdin        = sdin_q;

    // Staging occupancy: a load empties it, an accept fills it.
    // Accept only happens when empty, so the two never collide.
    always_comb begin
        full_d = full_q;
        if (load && full_q) begin
            full_d = 1'b0;
        end
        if (accept) begin
            full_d = 1'b1;
        end
    end

    // Staging register and registered ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            full_q  <= 1'b0;
            ready_q <= 1'b0;
            stg_l_q <= '0;
            stg_r_q <= '0;
        end else begin
            full_q  <= full_d;
            ready_q <= ~full_d;
            if (accept) begin
                stg_l_q <= s_if.sample_left;
                stg_r_q <= s_if.sample_right;
            end
        end
    end

    // Active pair swaps at the frame boundary; mute zeroes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            act_l_q <= '0;
            act_r_q <= '0;
        end else if (load) begin
            if (mute) begin
                act_l_q <= '0;
                act_r_q <= '0;
            end else if (full_q) begin
                act_l_q <= stg_l_q;
                act_r_q <= stg_r_q;
            end
        end
    end

    // Bit for the upcoming slot: MSB in slot 1, zero padding after.
    always_comb begin
        si     = 32'(slot);
        in_rng = (si >= 1) && (si <= SAMPLE_W) && (si < SLOT_W);
        idx    = IDX_W'(SAMPLE_W - si);
        sdin_d = sdin_q;
        if (bit_edge) begin
            sdin_d = in_rng & (nxt_lr ? act_r_q[idx] : act_l_q[idx]);
        end
    end

    // sdin changes with the sck falling edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sdin_q <= 1'b0;
        end else begin
            sdin_q <= sdin_d;
        end
    end
endmodule

// File: tb/tb_audio_i2s_tx.sv
// Bench for audio_i2s_tx: frame-level model plus directed scenarios.
// Model works in cycle position p within a 1024-cycle frame.
module tb_audio_i2s_tx;

    logic clk = 1'b0;
    logic rst;
    logic mute;
    logic underrun;
    logic audio_mclk;
    logic audio_lrck;
    logic audio_sck;
    logic audio_sdin;

    audio_i2s_tx_if s_if ();

    audio_i2s_tx dut (
        .clk        (clk),
        .rst        (rst),
        .s_if       (s_if),
        .mute       (mute),
        .underrun   (underrun),
        .audio_mclk (audio_mclk),
        .audio_lrck (audio_lrck),
        .audio_sck  (audio_sck),
        .audio_sdin (audio_sdin)
    );

    always #5 clk = ~clk;

    int cmp = 0;
    int bad = 0;

    // Model state
    int          p = 0;
    bit          known = 0;
    bit          rdy_ok = 0;
    logic [15:0] fr_l = 0;
    logic [15:0] fr_r = 0;
    logic [15:0] sq_l[$];
    logic [15:0] sq_r[$];

    // Capture of what the DUT actually serialised, per frame
    logic [15:0] cur_l = 0;
    logic [15:0] cur_r = 0;
    int          cur_ur = 0;
    logic [15:0] last_l = 0;
    logic [15:0] last_r = 0;
    int          last_ur = 0;

    bit acc_prev = 0;
    int n_acc = 0;
    bit inc_mode = 0;

    task automatic chk(input string nm, input logic [31:0] a,
                       input logic [31:0] e);
        cmp++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, a, e);
        end
    endtask

    // Per-cycle comparison and model advance.
    always @(negedge clk) begin
        logic [5:0]  av;
        logic [5:0]  ev;
        logic [15:0] w;
        logic        e_sd;
        logic        e_rdy;
        logic        e_ur;
        int          b;
        int          ch;
        e_rdy = 1'b0;
        if (known) begin
            ch    = p / 512;
            b     = (p % 512) / 16;
            w     = ch ? fr_r : fr_l;
            e_sd  = (b >= 1 && b <= 16) ?
                    w[4'(16 - b)] : 1'b0;
            e_rdy = rdy_ok && (sq_l.size() == 0);
            e_ur  = (p == 1023) && (sq_l.size() == 0) && !rst;
            ev = {((p / 2) % 2) == 1, ((p / 8) % 2) == 1,
                  ch == 1, e_sd, e_ur, e_rdy};
            av = {audio_mclk, audio_sck, audio_lrck,
                  audio_sdin, underrun, s_if.sample_ready};
            cmp++;
            if (av !== ev) begin
                bad++;
                $display("FAIL cycle p=%0d {mclk,sck,lrck,sdin,ur,rdy} got %b expected %b",
                         p, av, ev);
            end
            if ((p % 16) == 8 && b >= 1 && b <= 16) begin
                if (ch == 1) cur_r[4'(16 - b)] = audio_sdin;
                else         cur_l[4'(16 - b)] = audio_sdin;
            end
            if (underrun) cur_ur++;
            if (p == 1023) begin
                last_l = cur_l;
                last_r = cur_r;
                last_ur = cur_ur;
                cur_l = 0;
                cur_r = 0;
                cur_ur = 0;
            end
            acc_prev = s_if.sample_valid && s_if.sample_ready;
            if (acc_prev) n_acc++;
        end
        if (rst) begin
            p = 0;
            fr_l = 0;
            fr_r = 0;
            sq_l.delete();
            sq_r.delete();
            rdy_ok = 0;
            known = 1;
            cur_l = 0;
            cur_r = 0;
            cur_ur = 0;
            acc_prev = 0;
        end else if (known) begin
            if (p == 1023) begin
                if (sq_l.size() != 0) begin
                    fr_l = sq_l.pop_front();
                    fr_r = sq_r.pop_front();
                end
                if (mute) begin
                    fr_l = 0;
                    fr_r = 0;
                end
            end
            if (s_if.sample_valid && e_rdy) begin
                sq_l.push_back(s_if.sample_left);
                sq_r.push_back(s_if.sample_right);
            end
            rdy_ok = 1;
            p = (p + 1) % 1024;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (inc_mode && acc_prev)
            s_if.sample_left = s_if.sample_left + 16'd1;
    endtask

    task automatic wait_p(input int t);
        int n = 0;
        while (p != t && n < 4096) begin
            step();
            n++;
        end
        if (p != t) chk("wait_p timeout", 32'(p), 32'(t));
    endtask

    task automatic next_frame();
        wait_p(1023);
        step();
    endtask

    task automatic offer(input logic [15:0] l, input logic [15:0] r);
        bit got = 0;
        int n = 0;
        s_if.sample_left  = l;
        s_if.sample_right = r;
        s_if.sample_valid = 1'b1;
        while (!got && n < 3000) begin
            @(negedge clk);
            got = s_if.sample_valid && s_if.sample_ready;
            @(posedge clk);
            #1;
            n++;
        end
        s_if.sample_valid = 1'b0;
        if (!got) chk("offer timeout", 32'(n), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        mute = 1'b0;
        s_if.sample_left = 0;
        s_if.sample_right = 0;
        s_if.sample_valid = 1'b0;
        repeat (3) step();
        rst = 1'b0;

        // Idle frame: underrun once, silent data
        next_frame();
        chk("idle ur", 32'(last_ur), 32'd1);
        chk("idle data", {last_l, last_r}, 32'd0);

        // Single pair, then starve
        wait_p(100);
        offer(16'hA5C3, 16'h0001);
        next_frame();
        chk("load ur", 32'(last_ur), 32'd0);
        next_frame();
        chk("frame L", 32'(last_l), 32'h0000A5C3);
        chk("frame R", 32'(last_r), 32'h00000001);
        chk("frame ur", 32'(last_ur), 32'd1);
        next_frame();
        chk("repeat L", 32'(last_l), 32'h0000A5C3);
        chk("repeat R", 32'(last_r), 32'h00000001);
        chk("repeat ur", 32'(last_ur), 32'd1);

        // Continuous valid with incrementing left
        s_if.sample_left = 16'h0100;
        s_if.sample_right = 16'h0200;
        s_if.sample_valid = 1'b1;
        inc_mode = 1;
        n_acc = 0;
        next_frame();
        chk("strm0 L", 32'(last_l), 32'h0000A5C3);
        chk("strm0 ur", 32'(last_ur), 32'd0);
        next_frame();
        chk("strm1 L", 32'(last_l), 32'h00000100);
        chk("strm1 ur", 32'(last_ur), 32'd0);
        next_frame();
        chk("strm2 L", 32'(last_l), 32'h00000101);
        chk("strm2 R", 32'(last_r), 32'h00000200);
        next_frame();
        chk("strm3 L", 32'(last_l), 32'h00000102);
        chk("accepts", 32'(n_acc), 32'd4);
        s_if.sample_valid = 1'b0;
        inc_mode = 0;

        // Mute over a staged pair
        offer(16'h7FFF, 16'h8000);
        wait_p(1000);
        mute = 1'b1;
        next_frame();
        chk("strm4 L", 32'(last_l), 32'h00000103);
        @(negedge clk);
        chk("ready after mute load", 32'(s_if.sample_ready), 32'd1);
        wait_p(100);
        mute = 1'b0;
        offer(16'h1234, 16'h5678);
        next_frame();
        chk("muted frame", {last_l, last_r}, 32'd0);
        next_frame();
        chk("unmuted frame", {last_l, last_r}, 32'h12345678);

        // Reset mid-frame with a staged pair
        offer(16'hBEEF, 16'hCAFE);
        wait_p(300);
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("reset outputs",
            {26'd0, audio_mclk, audio_sck, audio_lrck,
             audio_sdin, underrun, s_if.sample_ready}, 32'd0);
        next_frame();
        chk("post-reset ur", 32'(last_ur), 32'd1);
        chk("post-reset data", {last_l, last_r}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 cmp, bad);
        $finish;
    end

endmodule

// File: doc/audio_i2s_tx.md
Name: audio_i2s_tx

Overview:
- Downstream serializer for the speaker path: takes one 16-bit stereo sample per frame and drives the four Pmod I2S pins (mclk, lrck, sck, sdin) for the CS4344 DAC.
- One instance per audio output group; the note/volume mixer feeds it through a valid/ready handshake.
- Replaces free-running divider logic with a frame-aligned, handshaked transmitter that provides underrun reporting and mute.

Parameters:
- SAMPLE_W, 16: sample width per channel, two's complement.
- SLOT_W, 32: sck periods per channel slot; SLOT_W > SAMPLE_W is required.

Ports:
- clk  in  1  100 MHz system clock.
- rst  in  1  Synchronous, active-high reset.
- sample_left  in  SAMPLE_W  Left sample.
- sample_right  in  SAMPLE_W  Right sample.
- sample_valid  in  1  Producer offers a sample pair.
- sample_ready  out  1  Staging register empty. The pair transfers on a cycle where valid and ready are both high.
- mute  in  1  Sampled at frame load; when high, the loaded frame is zero.
- underrun  out  1  One-cycle pulse: a frame started with no staged sample.
- audio_mclk  out  1  Master clock = clk/4.
- audio_lrck  out  1  Word select: 0 = left, 1 = right. Frequency = clk/1024.
- audio_sck  out  1  Serial clock = clk/16.
- audio_sdin  out  1  Serial data, I2S format.

Behaviour:
- Free-running 10-bit counter cnt, +1 per clk, wraps 1023 -> 0.
  - audio_mclk = cnt[1]
  - audio_sck = cnt[3]
  - audio_lrck = cnt[9]
  - slot = cnt[8:4] (0..31)
- Staging register (left, right, full flag):
  - sample_ready = !full.
  - On a valid & ready cycle: capture the pair, set full.
- Frame load occurs on the cycle where cnt == 1023:
  - If full: active_l/active_r <= staged pair (or zero if mute), clear full.
  - If not full: active pair holds its previous value (or zero if mute), and underrun = 1 for this cycle.
- Simultaneous load and valid with full = 0: the load takes the underrun path; the new pair goes into staging, is used at the next frame, and no data is lost.
- sample_ready is a registered function of full. It is 1 the cycle after a load that emptied staging.
- sdin is registered and updated on cycles where cnt[3:0] == 15, so it changes coincident with the sck falling edge.
  - Value for the upcoming slot s on channel c (c = next cnt[9]):
    - s in 1..SAMPLE_W: active_c[SAMPLE_W - s], so the MSB appears one sck after the lrck edge.
    - s == 0 or s > SAMPLE_W: 0.
- Sample-to-pin latency:
  - Pair accepted before a load is emitted in the frame starting the next cycle.
  - Left MSB appears on sdin at cnt = 16 of that frame.
- Reset (rst high):
  - cnt = 0, full = 0, active pair = 0.
  - audio_sdin = 0, underrun = 0, all derived clocks 0, sample_ready = 0.
  - sample_ready rises the cycle after rst falls.
  - Reset mid-frame aborts the frame immediately; the staged pair is discarded.
- The producer must hold sample_left, sample_right and sample_valid stable while valid is high and ready is low.

Decomposition:
- Package audio_pkg holds:
  - SAMPLE_W
  - CNT_W = 10
  - LOAD_CNT = 1023
  - Bit-index constants MCLK_BIT = 1, SCK_BIT = 3, LRCK_BIT = 9
- Sub-module i2s_clkgen: counter plus mclk/sck/lrck, slot index and load strobe outputs.
- audio_i2s_tx holds the staging handshake, active registers and sdin mux.

Test Plan:
1. Release rst at cycle 0, hold idle. Expect:
   - mclk period 4, sck period 16, lrck period 1024, lrck low for cnt 0..511.
   - sdin = 0 throughout.
   - underrun pulses at every cnt == 1023.
2. Offer left = 16'hA5C3, right = 16'h0001 before the first load. Expect:
   - Left slots 1..16 shift out 1010 0101 1100 0011 MSB-first, changing on sck falling edges; slots 0 and 17..31 are 0.
   - Right channel shows only slot 16 = 1.
   - underrun stays 0 at that load.
3. Offer one pair, then stop supplying. Expect:
   - Next frame repeats the same bits.
   - underrun pulses once per frame.
   - sample_ready = 1 throughout.
4. Hold valid continuously with an incrementing left value. Expect:
   - ready drops after each accept and rises one cycle after each load.
   - Exactly one pair is consumed per 1024 cycles.
   - Frames carry consecutive values with no skip or duplicate.
5. Assert mute with a staged pair 16'h7FFF/16'h8000. Expect:
   - Frame sdin is all zero.
   - Staging is cleared and ready = 1 after the load.
   - Deasserting mute before the next load restores data.
6. Assert rst at cnt = 300 with a pair staged. Expect:
   - All outputs 0 the next cycle.
   - After release, cnt restarts at 0 and the first load reports underrun.
